debounce_boton: RTL and testbench
=================================

# debounce_boton

Debouncer placed directly upstream of the push-button edge-pulse stage. It synchronises a raw, bouncing mechanical button input to `clk` and produces a clean level. The level changes only after the synchronised input has held a new value for `DEBOUNCE_CYCLES` consecutive cycles. The downstream pulse stage consumes `btn_clean` and turns each debounced press into a single-cycle pulse. An optional long-press detector flags presses held beyond a second threshold.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stability window in `clk` cycles (10 ms at 100 MHz). Must be ≥ 2.
- `HOLD_CYCLES`, default 100_000_000: cycles `btn_clean` must stay high before `btn_long` fires (1 s at 100 MHz). Must be ≥ 1. Used only with `DEBOUNCE_HOLD_EN`.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `rst`  input  1  reset; synchronous, active-low (reset when `rst`=0 at a rising edge of `clk`).
- `btn_raw`  input  1  asynchronous raw button level, active-high.
- `btn_clean`  output  1  debounced, synchronised button level.
- `btn_long`  output  1  one-cycle pulse when a press has lasted `HOLD_CYCLES`. Constant 0 without `DEBOUNCE_HOLD_EN`.

## Operation
- **Synchroniser:** two flops, `sync1 <= btn_raw`, `sync2 <= sync1`. Only `sync2` feeds the filter.
- **Filter FSM**, two states; the state of `btn_clean` is held separately:
  - STABLE: `sync2 == btn_clean`, counter = 0. If `sync2 != btn_clean`, move to FILTER and set counter = 1.
  - FILTER: on each edge with `sync2 != btn_clean`, increment the counter. When the counter equals `DEBOUNCE_CYCLES-1` and `sync2` still differs, toggle `btn_clean`, clear the counter and go to STABLE. Any edge with `sync2 == btn_clean` clears the counter and returns to STABLE with `btn_clean` unchanged.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES)` bits. The counter never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- **Glitches:** any excursion of `sync2` shorter than `DEBOUNCE_CYCLES` cycles leaves `btn_clean` unchanged. The count restarts from 0 on every return to the stable value.
- **Symmetry:** press and release are filtered identically.
- **Reset values:** `sync1`, `sync2`, `btn_clean`, `btn_long` = 0; counters = 0; FSM in STABLE. Reset mid-filter abandons the count. If `btn_raw` is high during and after reset, the rise is qualified from scratch, timed from the first edge after release.

## Timing
- If `btn_raw` is stable at a new value from edge k onward (sampled into `sync1` at edge k), `btn_clean` updates at edge k+1+`DEBOUNCE_CYCLES`.
- Example with `DEBOUNCE_CYCLES`=4: `btn_raw` rises before edge 0 → `btn_clean`=1 after edge 5.
- `btn_clean` changes at most once per `DEBOUNCE_CYCLES` cycles.
- `btn_clean` is a registered output with no combinational path from `btn_raw`.
- `btn_long`: registered, high for exactly one cycle, at the edge where `btn_clean` has been 1 for `HOLD_CYCLES` consecutive cycles. It fires at most once per press.

## Configuration
- **Macro:** `DEBOUNCE_HOLD_EN`.
- **Defined:**
  - A hold counter of `$clog2(HOLD_CYCLES+1)` bits runs while `btn_clean`=1 and saturates after firing.
  - The counter clears when `btn_clean`=0 or in reset.
  - `btn_long` pulses as specified under Timing.
- **Undefined:** the hold counter is not instantiated and `btn_long` is tied to 0.
- Filter behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=10.
- **Reset:** hold `rst`=0 for 3 edges with `btn_raw`=1 → `btn_clean`=0 and `btn_long`=0 throughout reset. After release, `btn_clean`=1 at the 6th edge.
- **Clean press:** `btn_raw` 0→1 before edge 0, held → `btn_clean` rises after edge 5, not before. Release before edge 20 → `btn_clean` falls after edge 25.
- **Bounce:** `btn_raw` toggles 1,0,1,1,0,1 on consecutive cycles, then holds 1 → `btn_clean` rises exactly 5 edges after the last 0→1 sample.
- **Glitch rejection:** single 3-cycle high pulse on `btn_raw` → `btn_clean` stays 0.
- **Reset mid-filter:** `btn_raw` rises, `rst`=0 at edge 3 (counter = 2) → counter clears. After release, `btn_clean` rises only after a full 4-cycle qualification.
- **Long press (macro defined):** hold press → `btn_long`=1 for exactly one cycle, 10 edges after `btn_clean` rises. No further pulse while held. A second press repeats this. With the macro undefined, `btn_long` stays 0.

Source files
------------

// File: rtl/debounce_boton_if.sv
// Button signal bundle between the raw pad side and the debouncer.
// The master drives the raw level; the slave (debouncer) returns the clean level and long-press pulse.
interface debounce_boton_if;
  logic btn_raw;
  logic btn_clean;
  logic btn_long;

  modport master (
    output btn_raw,
    input  btn_clean,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_clean,
    output btn_long
  );
endinterface

// File: rtl/debounce_boton.sv
// Push-button debouncer: 2-flop synchroniser, stability filter, optional long-press pulse.
// Long-press detection is built only when DEBOUNCE_HOLD_EN is defined; otherwise btn_long is tied low.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_STABLE  | sync2 matches btn_clean, counter idle at 0
// ST_FILTER  | sync2 differs from btn_clean, counter timing the new level
module debounce_boton #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  debounce_boton_if.slave  bif
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_FILTER = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          clean_q, clean_d;

  always_comb begin
    sync1_d = bif.btn_raw;
    sync2_d = sync1_q;
  end

  // The counter only ever reaches CNT_LAST before toggling, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != clean_q) begin
          state_d = ST_FILTER;
          cnt_d   = CNT_ONE;
        end
      end
      ST_FILTER: begin
        if (sync2_q == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          clean_d = ~clean_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign bif.btn_clean = clean_q;

`ifdef DEBOUNCE_HOLD_EN
  localparam int            HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Saturating at HOLD_MAX is what limits the pulse to once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!clean_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = (hold_q == HOLD_FIRE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign bif.btn_long = long_q;
`else
  assign bif.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_boton.sv
// Directed bench for debounce_boton with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Expected levels are queued per edge as stimulus is applied and compared one edge later.
module tb_debounce_boton;
  localparam int DC = 4;
  localparam int HC = 10;
`ifdef DEBOUNCE_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debounce_boton_if bif ();

  debounce_boton #(
    .DEBOUNCE_CYCLES (DC),
    .HOLD_CYCLES     (HC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  typedef struct {
    logic  clean;
    logic  long_p;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic cur_clean = 1'b0;

  task automatic edge_check(input logic raw, input logic rst_v, input logic e_clean,
                            input logic e_long, input string tag);
    exp_t e;
    exp_t got;
    bif.btn_raw = raw;
    rst         = rst_v;
    e.clean  = e_clean;
    e.long_p = e_long;
    e.tag    = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1 at %s", tag);
    end
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      checks++;
      assert (bif.btn_clean === got.clean) else begin
        failures++;
        $error("FAIL %s btn_clean observed=%b expected=%b", got.tag, bif.btn_clean, got.clean);
      end
      checks++;
      assert (bif.btn_long === got.long_p) else begin
        failures++;
        $error("FAIL %s btn_long observed=%b expected=%b", got.tag, bif.btn_long, got.long_p);
      end
    end
  endtask

  // Holds raw for n edges; clean flips from edge 'flip' on (-1: never), long pulses at 'long_at'.
  task automatic seg(input logic raw, input int n, input int flip, input int long_at,
                     input string tag);
    logic e_clean;
    logic e_long;
    for (int i = 0; i < n; i++) begin
      e_clean = (flip >= 0 && i >= flip) ? ~cur_clean : cur_clean;
      e_long  = HOLD_EN && (i == long_at);
      edge_check(raw, 1'b1, e_clean, e_long, $sformatf("%s[%0d]", tag, i));
    end
    if (flip >= 0) cur_clean = ~cur_clean;
  endtask

  initial begin
    bif.btn_raw = 1'b0;
    rst         = 1'b0;

    for (int i = 0; i < 2; i++) edge_check(1'b0, 1'b0, 1'b0, 1'b0, "init");

    // Reset with button held: qualification starts at the first edge after release.
    for (int i = 0; i < 3; i++) edge_check(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rst_hold[%0d]", i));
    cur_clean = 1'b0;
    seg(1'b1, 20, 5, 15, "rst_rise");
    seg(1'b0, 8, 5, -1, "rst_fall");

    // Clean press and release.
    seg(1'b1, 20, 5, 15, "press");
    seg(1'b0, 8, 5, -1, "release");

    // Bounce 1,0,1,1,0 then settle high.
    seg(1'b1, 1, -1, -1, "bounce_a");
    seg(1'b0, 1, -1, -1, "bounce_b");
    seg(1'b1, 2, -1, -1, "bounce_c");
    seg(1'b0, 1, -1, -1, "bounce_d");
    seg(1'b1, 12, 5, -1, "bounce_hold");
    seg(1'b0, 8, 5, -1, "bounce_rel");

    // Three-cycle glitch must be ignored.
    seg(1'b1, 3, -1, -1, "glitch_hi");
    seg(1'b0, 8, -1, -1, "glitch_lo");

    // Reset in the middle of filtering a rise.
    seg(1'b1, 3, -1, -1, "mid_pre");
    edge_check(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    cur_clean = 1'b0;
    seg(1'b1, 20, 5, 15, "mid_rise");
    seg(1'b0, 8, 5, -1, "mid_fall");

    // Long presses: one pulse each, none while still held.
    seg(1'b1, 40, 5, 15, "long1");
    seg(1'b0, 8, 5, -1, "long1_rel");
    seg(1'b1, 40, 5, 15, "long2");
    seg(1'b0, 8, 5, -1, "long2_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
